// File: rtl/cnt_div_prog_if.sv
// Bundles the control and status signals of the programmable divide-by-N
// counter. The master side drives enable, resync and divisor loads; the
// slave side is the counter itself and returns count, strobes and status.
interface cnt_div_prog_if #(
  parameter int WIDTH  = 8,
  parameter int PCNT_W = 8
);
  logic              en;
  logic              sync_clr;
  logic [WIDTH-1:0]  div_in;
  logic              div_load;
  logic              div_busy;
  logic              div_ack;
  logic [WIDTH-1:0]  q;
  logic              q_cout;
  logic              q_half;
  logic [PCNT_W-1:0] q_periods;

  modport master (
    output en, sync_clr, div_in, div_load,
    input  div_busy, div_ack, q, q_cout, q_half, q_periods
  );

  modport slave (
    input  en, sync_clr, div_in, div_load,
    output div_busy, div_ack, q, q_cout, q_half, q_periods
  );
endinterface

// File: rtl/cnt_div_prog.sv
// Programmable divide-by-N counter supplying bit and half-bit timing to the
// Manchester encoder/decoder. A new divisor is requested through a load
// handshake and only takes effect on a period boundary (terminal count or
// resync), so a period is never cut short or stretched by a divisor change.
// Terminal-count and mid-period strobes are registered, giving the legacy
// one-cycle output latency.
module cnt_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DIV_DEFAULT = 2,
  parameter int PCNT_W      = 8
) (
  input logic            clk,
  input logic            reset,
  cnt_div_prog_if.slave  bus
);

  localparam logic [WIDTH-1:0]  DIV_RST = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0]  ONE     = WIDTH'(1);
  localparam logic [PCNT_W-1:0] P_ONE   = PCNT_W'(1);
  localparam logic [PCNT_W-1:0] P_MAX   = '1;

  logic [WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]  div_cur;
  logic [WIDTH-1:0]  div_pend;
  logic              pend;
  logic              q_cout;
  logic              q_half;
  logic              div_ack;
  logic [PCNT_W-1:0] q_periods;

  logic [WIDTH-1:0]  last_cnt;
  logic [WIDTH-1:0]  half_pt;
  logic [WIDTH-1:0]  div_req;
  logic              term;
  logic              hit;
  logic              apply;

  // Period boundary detection; a resync in the same cycle suppresses both strobes.
  always_comb begin
    last_cnt = div_cur - ONE;
    half_pt  = last_cnt >> 1;
    term     = bus.en & (cnt == last_cnt) & ~bus.sync_clr;
    hit      = bus.en & (cnt == half_pt) & ~bus.sync_clr;
    apply    = pend & (term | bus.sync_clr);
    div_req  = (bus.div_in == '0) ? ONE : bus.div_in;
  end

  // Main count: resync beats terminal wrap, which beats the enabled increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (bus.sync_clr) begin
      cnt <= '0;
    end else if (term) begin
      cnt <= '0;
    end else if (bus.en) begin
      cnt <= cnt + ONE;
    end
  end

  // Divisor handshake: the latest load wins, and a load landing on an apply
  // edge stays pending because the apply consumes the previous request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cur  <= DIV_RST;
      div_pend <= '0;
      pend     <= 1'b0;
      div_ack  <= 1'b0;
    end else begin
      div_ack <= apply;
      if (apply) begin
        div_cur <= div_pend;
      end
      if (bus.div_load) begin
        div_pend <= div_req;
        pend     <= 1'b1;
      end else if (apply) begin
        pend     <= 1'b0;
      end
    end
  end

  // Registered terminal-count and mid-period strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_cout <= 1'b0;
      q_half <= 1'b0;
    end else begin
      q_cout <= term;
      q_half <= hit;
    end
  end

  // Completed-period counter, cleared by resync and saturating at full scale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_periods <= '0;
    end else if (bus.sync_clr) begin
      q_periods <= '0;
    end else if (term && (q_periods != P_MAX)) begin
      q_periods <= q_periods + P_ONE;
    end
  end

  assign bus.q         = cnt;
  assign bus.q_cout    = q_cout;
  assign bus.q_half    = q_half;
  assign bus.div_busy  = pend;
  assign bus.div_ack   = div_ack;
  assign bus.q_periods = q_periods;

endmodule

// File: tb/tb_cnt_div_prog.sv
// Self-checking bench for cnt_div_prog. A behavioural model tracks the
// position inside the current period with modulo arithmetic, the pending
// divisor as a queue, and an unbounded period count that is clipped to each
// instance's width. A second instance with a 2-bit period counter shares
// all inputs to exercise saturation.
module tb_cnt_div_prog;

  logic clk;
  logic reset;

  cnt_div_prog_if #(.WIDTH(8), .PCNT_W(8)) mif ();
  cnt_div_prog_if #(.WIDTH(8), .PCNT_W(2)) sif ();

  cnt_div_prog #(.WIDTH(8), .DIV_DEFAULT(2), .PCNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  cnt_div_prog #(.WIDTH(8), .DIV_DEFAULT(2), .PCNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  assign sif.en       = mif.en;
  assign sif.sync_clr = mif.sync_clr;
  assign sif.div_in   = mif.div_in;
  assign sif.div_load = mif.div_load;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;

  // model state
  int m_pos;
  int m_div;
  int m_pend_q[$];
  int m_periods;

  // expectations for the cycle just stepped
  int e_cout, e_half, e_ack;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_div = 2;
    m_pend_q.delete();
    m_periods = 0;
  endtask

  task automatic check_all(input string tag);
    check_output({tag, ".q"}, 32'(mif.q), 32'(m_pos));
    check_output({tag, ".cout"}, 32'(mif.q_cout), 32'(e_cout));
    check_output({tag, ".half"}, 32'(mif.q_half), 32'(e_half));
    check_output({tag, ".busy"}, 32'(mif.div_busy), 32'(m_pend_q.size() > 0));
    check_output({tag, ".ack"}, 32'(mif.div_ack), 32'(e_ack));
    check_output({tag, ".periods"}, 32'(mif.q_periods), 32'(clip(m_periods, 255)));
    check_output({tag, ".sat_periods"}, 32'(sif.q_periods), 32'(clip(m_periods, 3)));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic apply_stimulus(input string tag, input bit en, input bit clr,
                                input int din, input bit load);
    bit term, hit, upd;
    mif.en       = en;
    mif.sync_clr = clr;
    mif.div_in   = 8'(din);
    mif.div_load = load;
    term = en && !clr && (((m_pos + 1) % m_div) == 0);
    hit  = en && !clr && (m_pos == (m_div - 1) / 2);
    upd  = (m_pend_q.size() > 0) && (term || clr);
    if (clr)      m_pos = 0;
    else if (en)  m_pos = (m_pos + 1) % m_div;
    if (upd)      m_div = m_pend_q.pop_front();
    if (load) begin
      m_pend_q.delete();
      m_pend_q.push_back((din == 0) ? 1 : din);
    end
    if (clr)       m_periods = 0;
    else if (term) m_periods++;
    e_cout = term;
    e_half = hit;
    e_ack  = upd;
    @(posedge clk);
    #1;
    if (mif.div_ack) ack_seen++;
    check_all(tag);
    mif.div_load = 1'b0;
    mif.sync_clr = 1'b0;
  endtask

  initial begin
    int g;
    reset = 1'b0;
    mif.en = 1'b0;
    mif.sync_clr = 1'b0;
    mif.div_in = '0;
    mif.div_load = 1'b0;
    model_reset();
    e_cout = 0; e_half = 0; e_ack = 0;
    #1;
    check_all("reset");
    #11;
    reset = 1'b1;

    // continuous count with the default divisor
    for (int i = 0; i < 10; i++) apply_stimulus("cont", 1, 0, 0, 0);
    check_output("cont.periods5", 32'(mif.q_periods), 32'd5);

    // load 5 at count 0
    apply_stimulus("load5", 1, 0, 5, 1);
    for (int i = 0; i < 14; i++) apply_stimulus("run5", 1, 0, 0, 0);

    // divisor 0 clamps to 1: strobes high continuously
    g = 0;
    while (m_pos != 0 && g < 20) begin apply_stimulus("align", 1, 0, 0, 0); g++; end
    apply_stimulus("load0", 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) apply_stimulus("run1", 1, 0, 0, 0);
    check_output("div1.cout", 32'(mif.q_cout), 32'd1);
    check_output("div1.half", 32'(mif.q_half), 32'd1);

    // two loads within one period give a single ack
    apply_stimulus("load8", 1, 0, 8, 1);
    apply_stimulus("apply8", 1, 0, 0, 0);
    ack_seen = 0;
    apply_stimulus("load7", 1, 0, 7, 1);
    apply_stimulus("load3", 1, 0, 3, 1);
    for (int i = 0; i < 12; i++) apply_stimulus("run3", 1, 0, 0, 0);
    check_output("two_loads.acks", 32'(ack_seen), 32'd1);

    // resync at count 3 with divisor 8 applies a pending divisor
    apply_stimulus("load8b", 1, 0, 8, 1);
    g = 0;
    while (m_pend_q.size() > 0 && g < 20) begin apply_stimulus("wait8", 1, 0, 0, 0); g++; end
    g = 0;
    while (m_pos != 2 && g < 20) begin apply_stimulus("to2", 1, 0, 0, 0); g++; end
    check_output("reach_cnt2", 32'(m_pos == 2 && m_div == 8), 32'd1);
    apply_stimulus("load6", 1, 0, 6, 1);
    apply_stimulus("sync", 1, 1, 0, 0);
    check_output("sync.q", 32'(mif.q), 32'd0);
    check_output("sync.cout", 32'(mif.q_cout), 32'd0);
    check_output("sync.periods", 32'(mif.q_periods), 32'd0);
    check_output("sync.ack", 32'(mif.div_ack), 32'd1);
    for (int i = 0; i < 10; i++) apply_stimulus("run6", 1, 0, 0, 0);

    // enable gaps with divisor 4
    apply_stimulus("load4", 1, 0, 4, 1);
    for (int i = 0; i < 24; i++) apply_stimulus("gaps", (i % 3) != 1, 0, 0, 0);

    // saturation of the 2-bit period counter
    apply_stimulus("sat_clr", 1, 1, 0, 0);
    for (int i = 0; i < 26; i++) apply_stimulus("sat", 1, 0, 0, 0);
    check_output("sat.q_periods", 32'(sif.q_periods), 32'd3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      apply_stimulus("rand",
                     $urandom_range(0, 9) < 8,
                     $urandom_range(0, 39) == 0,
                     ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)),
                     $urandom_range(0, 9) == 0);
    end

    // async reset at count 6 with divisor 9 and a divisor pending
    apply_stimulus("load9", 1, 0, 9, 1);
    g = 0;
    while (m_pend_q.size() > 0 && g < 40) begin apply_stimulus("wait9", 1, 0, 0, 0); g++; end
    g = 0;
    while (m_pos != 5 && g < 20) begin apply_stimulus("to5", 1, 0, 0, 0); g++; end
    apply_stimulus("loadp", 1, 0, 4, 1);
    check_output("pre_rst.state", 32'(mif.q == 6 && mif.div_busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    e_cout = 0; e_half = 0; e_ack = 0;
    check_all("async_rst");
    #2;
    reset = 1'b1;
    apply_stimulus("rel1", 1, 0, 0, 0);
    check_output("rel.first_q", 32'(mif.q), 32'd1);
    apply_stimulus("rel2", 1, 0, 0, 0);
    check_output("rel.cout_div2", 32'(mif.q_cout), 32'd1);
    check_output("rel.busy", 32'(mif.div_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
